// File: rtl/hazard3_ahb_arb2.sv
// Two-master to one-slave AHB5 arbiter with per-master address skid buffers.
// Define HAZARD3_ARB_RR_EN for round-robin tie-breaking (default: m0 beats m1).
module hazard3_ahb_arb2 #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_ADDR-1:0] m0_haddr,
  input  logic              m0_hwrite,
  input  logic [1:0]        m0_htrans,
  input  logic [2:0]        m0_hsize,
  input  logic [2:0]        m0_hburst,
  input  logic [3:0]        m0_hprot,
  input  logic              m0_hmastlock,
  input  logic              m0_hexcl,
  input  logic [W_DATA-1:0] m0_hwdata,
  output logic              m0_hready,
  output logic              m0_hresp,
  output logic              m0_hexokay,
  output logic [W_DATA-1:0] m0_hrdata,
  input  logic [W_ADDR-1:0] m1_haddr,
  input  logic              m1_hwrite,
  input  logic [1:0]        m1_htrans,
  input  logic [2:0]        m1_hsize,
  input  logic [2:0]        m1_hburst,
  input  logic [3:0]        m1_hprot,
  input  logic              m1_hmastlock,
  input  logic              m1_hexcl,
  input  logic [W_DATA-1:0] m1_hwdata,
  output logic              m1_hready,
  output logic              m1_hresp,
  output logic              m1_hexokay,
  output logic [W_DATA-1:0] m1_hrdata,
  output logic [W_ADDR-1:0] s_haddr,
  output logic              s_hwrite,
  output logic [1:0]        s_htrans,
  output logic [2:0]        s_hsize,
  output logic [2:0]        s_hburst,
  output logic [3:0]        s_hprot,
  output logic              s_hmastlock,
  output logic              s_hexcl,
  output logic [7:0]        s_hmaster,
  output logic [W_DATA-1:0] s_hwdata,
  input  logic              s_hready,
  input  logic              s_hresp,
  input  logic              s_hexokay,
  input  logic [W_DATA-1:0] s_hrdata,
  output logic [3:0]        dbg_state
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [1:0]        trans;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              mastlock;
    logic              excl;
  } ap_t;

  // A master is idle, waiting with its address in the skid buffer, or owns the data phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUF  = 2'd1,
    ST_DPH  = 2'd2
  } mst_state_t;

  // Handshake: an address is accepted from master N at a rising edge where mN_hready=1;
  // it is then either issued downstream (s_hready=1 and granted) or parked in the buffer.
  ap_t        live [2];
  ap_t        held [2];
  ap_t        cand [2];
  ap_t        last_ap;
  ap_t        s_ap;
  mst_state_t st [2];
  logic [1:0] req;
  logic [1:0] hready_int;
  logic       owner_v, owner, hold;
  logic       win_v, win, issue, tie_win;
  logic       dph_lock, pend_v, pend_m, last_m;

  assign live[0] = {m0_haddr, m0_hwrite, m0_htrans, m0_hsize, m0_hburst, m0_hprot,
                    m0_hmastlock, m0_hexcl};
  assign live[1] = {m1_haddr, m1_hwrite, m1_htrans, m1_hsize, m1_hburst, m1_hprot,
                    m1_hmastlock, m1_hexcl};

`ifdef HAZARD3_ARB_RR_EN
  logic last_gnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_gnt <= 1'b1;
    else if (issue) last_gnt <= win;
  end
  assign tie_win = ~last_gnt;
`else
  assign tie_win = 1'b0;
`endif

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      req[n]  = (st[n] == ST_BUF) || live[n].trans[1];
      cand[n] = (st[n] == ST_BUF) ? held[n] : live[n];
      case (st[n])
        ST_DPH:  hready_int[n] = s_hready;
        ST_BUF:  hready_int[n] = 1'b0;
        default: hready_int[n] = 1'b1;
      endcase
    end
    owner_v = (st[0] == ST_DPH) || (st[1] == ST_DPH);
    owner   = (st[1] == ST_DPH);
    // Locked sequences and bursts keep the bus with the current owner.
    hold    = owner_v && (dph_lock || live[owner].trans == HTRANS_SEQ ||
                          live[owner].trans == HTRANS_BUSY);
    win_v = 1'b0;
    win   = 1'b0;
    // An address shown during a wait state stays on the bus until accepted.
    if (pend_v && req[pend_m]) begin
      win_v = 1'b1;
      win   = pend_m;
    end else if (hold) begin
      win_v = req[owner];
      win   = owner;
    end else if (req[0] && req[1]) begin
      win_v = 1'b1;
      win   = tie_win;
    end else if (req[0] || req[1]) begin
      win_v = 1'b1;
      win   = ~req[0];
    end
  end

  assign issue = win_v && s_hready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0]    <= ST_IDLE;
      st[1]    <= ST_IDLE;
      held[0]  <= '0;
      held[1]  <= '0;
      last_ap  <= '0;
      last_m   <= 1'b0;
      dph_lock <= 1'b0;
      pend_v   <= 1'b0;
      pend_m   <= 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (issue && (int'(win) == n)) begin
          st[n] <= ST_DPH;
        end else if (hready_int[n] && live[n].trans[1]) begin
          st[n]   <= ST_BUF;
          held[n] <= live[n];
        end else if (st[n] == ST_DPH && !s_hready) begin
          st[n] <= ST_DPH;
        end else if (st[n] != ST_BUF) begin
          st[n] <= ST_IDLE;
        end
      end
      if (win_v) begin
        last_ap <= cand[win];
        last_m  <= win;
      end
      pend_v <= win_v && !s_hready;
      pend_m <= win;
      if (issue)         dph_lock <= cand[win].mastlock;
      else if (s_hready) dph_lock <= 1'b0;
    end
  end

  assign s_ap        = win_v ? cand[win] : last_ap;
  assign s_haddr     = s_ap.addr;
  assign s_hwrite    = s_ap.write;
  assign s_htrans    = win_v ? s_ap.trans : HTRANS_IDLE;
  assign s_hsize     = s_ap.size;
  assign s_hburst    = s_ap.burst;
  assign s_hprot     = s_ap.prot;
  assign s_hmastlock = s_ap.mastlock;
  assign s_hexcl     = s_ap.excl;
  assign s_hmaster   = {7'd0, (win_v ? win : last_m)};
  assign s_hwdata    = owner ? m1_hwdata : m0_hwdata;

  assign m0_hready  = hready_int[0];
  assign m0_hresp   = (st[0] == ST_DPH) && s_hresp;
  assign m0_hexokay = (st[0] == ST_DPH) && s_hexokay;
  assign m0_hrdata  = (st[0] == ST_DPH) ? s_hrdata : '0;
  assign m1_hready  = hready_int[1];
  assign m1_hresp   = (st[1] == ST_DPH) && s_hresp;
  assign m1_hexokay = (st[1] == ST_DPH) && s_hexokay;
  assign m1_hrdata  = (st[1] == ST_DPH) ? s_hrdata : '0;

  assign dbg_state = {st[1], st[0]};

endmodule

// File: tb/tb_hazard3_ahb_arb2.sv
// Directed-vector bench for hazard3_ahb_arb2: single transfers, contention, lock,
// error forwarding, arbitration order and asynchronous reset.
module tb_hazard3_ahb_arb2;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSEQ = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, m0_hrdata, m1_hrdata;
  logic        m0_hwrite, m1_hwrite, m0_hmastlock, m1_hmastlock, m0_hexcl, m1_hexcl;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp, m0_hexokay, m1_hexokay;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hmastlock, s_hexcl, s_hready, s_hresp, s_hexokay;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [7:0]  s_hmaster;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  hazard3_ahb_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_haddr(m0_haddr), .m0_hwrite(m0_hwrite), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hprot(m0_hprot), .m0_hmastlock(m0_hmastlock),
    .m0_hexcl(m0_hexcl), .m0_hwdata(m0_hwdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m0_hexokay(m0_hexokay), .m0_hrdata(m0_hrdata),
    .m1_haddr(m1_haddr), .m1_hwrite(m1_hwrite), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hprot(m1_hprot), .m1_hmastlock(m1_hmastlock),
    .m1_hexcl(m1_hexcl), .m1_hwdata(m1_hwdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .m1_hexokay(m1_hexokay), .m1_hrdata(m1_hrdata),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hexcl(s_hexcl),
    .s_hmaster(s_hmaster), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hresp(s_hresp),
    .s_hexokay(s_hexokay), .s_hrdata(s_hrdata), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic drive_m0(input logic [1:0] t, input logic [31:0] a, input logic w,
                          input logic l);
    m0_htrans = t; m0_haddr = a; m0_hwrite = w; m0_hmastlock = l;
  endtask

  task automatic drive_m1(input logic [1:0] t, input logic [31:0] a, input logic w,
                          input logic l);
    m1_htrans = t; m1_haddr = a; m1_hwrite = w; m1_hmastlock = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_m0(IDLE, 32'h0, 1'b0, 1'b0);
    drive_m1(IDLE, 32'h0, 1'b0, 1'b0);
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    m0_hsize = 3'd2; m1_hsize = 3'd2; m0_hburst = 3'd0; m1_hburst = 3'd0;
    m0_hprot = 4'h3; m1_hprot = 4'h3; m0_hexcl = 1'b0; m1_hexcl = 1'b0;
    m0_hwdata = '0; m1_hwdata = '0; s_hexokay = 1'b0;
    do_reset();
    rst_n = 1'b0;

    // Reset values while held in reset
    @(negedge clk);
    check("rst_htrans", s_htrans, 0);
    check("rst_haddr", s_haddr, 0);
    check("rst_hmaster", s_hmaster, 0);
    check("rst_m0_hready", m0_hready, 1);
    check("rst_m1_hready", m1_hready, 1);
    check("rst_m1_hresp", m1_hresp, 0);
    check("rst_m0_hrdata", m0_hrdata, 0);
    check("rst_state", dbg_state, 0);
    next_cycle();
    rst_n = 1'b1;

    // Single m0 read, zero added latency
    drive_m0(NSEQ, 32'h40, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_htrans", s_htrans, 2);
    check("t1_haddr", s_haddr, 32'h40);
    check("t1_hmaster", s_hmaster, 0);
    check("t1_m0_hready_a", m0_hready, 1);
    next_cycle();
    drive_m0(IDLE, 32'h0, 1'b0, 1'b0);
    s_hrdata = 32'h12345678;
    @(negedge clk);
    check("t1_m0_hrdata", m0_hrdata, 32'h12345678);
    check("t1_m0_hready_d", m0_hready, 1);
    check("t1_m1_hrdata", m1_hrdata, 0);
    check("t1_m1_hready", m1_hready, 1);
    check("t1_idle", s_htrans, 0);
    check("t1_haddr_hold", s_haddr, 32'h40);
    next_cycle();
    s_hrdata = '0;

    // Simultaneous NSEQ: m0 write issued, m1 read buffered then issued
    do_reset();
    drive_m0(NSEQ, 32'h100, 1'b1, 1'b0);
    drive_m1(NSEQ, 32'h200, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_haddr0", s_haddr, 32'h100);
    check("t2_hmaster0", s_hmaster, 0);
    check("t2_hwrite0", s_hwrite, 1);
    check("t2_m1_hready0", m1_hready, 1);
    next_cycle();
    drive_m0(IDLE, 32'h0, 1'b0, 1'b0);
    drive_m1(IDLE, 32'h0, 1'b0, 1'b0);
    m0_hwdata = 32'hcafef00d;
    @(negedge clk);
    check("t2_haddr1", s_haddr, 32'h200);
    check("t2_hmaster1", s_hmaster, 1);
    check("t2_htrans1", s_htrans, 2);
    check("t2_m1_hready1", m1_hready, 0);
    check("t2_m0_hready1", m0_hready, 1);
    check("t2_hwdata", s_hwdata, 32'hcafef00d);
    next_cycle();
    s_hrdata = 32'h0badbeef;
    @(negedge clk);
    check("t2_m1_hready2", m1_hready, 1);
    check("t2_m1_hrdata", m1_hrdata, 32'h0badbeef);
    check("t2_m0_hrdata", m0_hrdata, 0);
    check("t2_idle", s_htrans, 0);
    next_cycle();
    s_hrdata = '0;

    // m0 locked sequence of three, then one unlocked; m1 waits throughout
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive_m0(NSEQ, 32'h300 + 32'(4 * k), 1'b0, k < 3);
      else       drive_m0(IDLE, 32'h0, 1'b0, 1'b0);
      if (k == 0) drive_m1(NSEQ, 32'h400, 1'b0, 1'b0);
      else        drive_m1(IDLE, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("t3_hmaster_%0d", k), s_hmaster, (k == 4) ? 1 : 0);
      check($sformatf("t3_haddr_%0d", k), s_haddr, (k < 4) ? 32'h300 + 32'(4 * k) : 32'h400);
      check($sformatf("t3_m1_hready_%0d", k), m1_hready, (k == 0) ? 1 : 0);
      next_cycle();
    end
    @(negedge clk);
    check("t3_m1_done", m1_hready, 1);
    check("t3_idle", s_htrans, 0);
    next_cycle();
    next_cycle();

    // Two-cycle error on m1 read; next address dropped when m1 goes IDLE
    drive_m1(NSEQ, 32'h500, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_hmaster", s_hmaster, 1);
    next_cycle();
    drive_m1(NSEQ, 32'h504, 1'b0, 1'b0);
    s_hready = 1'b0; s_hresp = 1'b1;
    @(negedge clk);
    check("t4_e1_hresp", m1_hresp, 1);
    check("t4_e1_hready", m1_hready, 0);
    check("t4_e1_m0_hresp", m0_hresp, 0);
    check("t4_e1_htrans", s_htrans, 2);
    next_cycle();
    drive_m1(IDLE, 32'h0, 1'b0, 1'b0);
    s_hready = 1'b1;
    @(negedge clk);
    check("t4_e2_hresp", m1_hresp, 1);
    check("t4_e2_hready", m1_hready, 1);
    check("t4_e2_m0_hresp", m0_hresp, 0);
    check("t4_e2_htrans", s_htrans, 0);
    next_cycle();
    s_hresp = 1'b0;
    @(negedge clk);
    check("t4_after_htrans", s_htrans, 0);
    check("t4_after_state", dbg_state, 0);
    check("t4_after_hresp", m1_hresp, 0);
    next_cycle();

    // Both masters request four transfers each, continuously
    do_reset();
`ifdef HAZARD3_ARB_RR_EN
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({8'd0, 32'h1000 + 32'(4 * k)});
      exp_q.push_back({8'd1, 32'h2000 + 32'(4 * k)});
    end
`else
    for (int k = 0; k < 4; k++) exp_q.push_back({8'd0, 32'h1000 + 32'(4 * k)});
    for (int k = 0; k < 4; k++) exp_q.push_back({8'd1, 32'h2000 + 32'(4 * k)});
`endif
    begin
      int i0, i1;
      logic h0, h1;
      i0 = 0; i1 = 0;
      for (int c = 0; c < 14; c++) begin
        drive_m0((i0 < 4) ? NSEQ : IDLE, 32'h1000 + 32'(4 * i0), 1'b0, 1'b0);
        drive_m1((i1 < 4) ? NSEQ : IDLE, 32'h2000 + 32'(4 * i1), 1'b0, 1'b0);
        @(negedge clk);
        h0 = m0_hready; h1 = m1_hready;
        if (s_htrans != IDLE) begin
          if (exp_q.size() > 0) check($sformatf("t5_issue_c%0d", c), {s_hmaster, s_haddr},
                                      exp_q.pop_front());
          else check($sformatf("t5_extra_c%0d", c), {s_hmaster, s_haddr}, 0);
        end
        next_cycle();
        if (h0 && i0 < 4) i0++;
        if (h1 && i1 < 4) i1++;
      end
    end
    check("t5_remaining", exp_q.size(), 0);
    next_cycle();

    // Asynchronous reset while m1 sits in its skid buffer
    do_reset();
    drive_m0(NSEQ, 32'h600, 1'b0, 1'b0);
    drive_m1(NSEQ, 32'h700, 1'b0, 1'b0);
    next_cycle();
    drive_m0(IDLE, 32'h0, 1'b0, 1'b0);
    drive_m1(IDLE, 32'h0, 1'b0, 1'b0);
    check("t6_buffered", dbg_state, 4'b0110);
    rst_n = 1'b0;
    #1;
    check("t6_rst_htrans", s_htrans, 0);
    check("t6_rst_haddr", s_haddr, 0);
    check("t6_rst_hmaster", s_hmaster, 0);
    check("t6_rst_m1_hready", m1_hready, 1);
    check("t6_rst_m0_hready", m0_hready, 1);
    check("t6_rst_state", dbg_state, 0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_htrans", s_htrans, 0);
    check("t6_post_m1_hready", m1_hready, 1);
    next_cycle();
    @(negedge clk);
    check("t6_post2_htrans", s_htrans, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
